// File: rtl/miriscv_wb_pkg.sv
// Shared types and widths for the writeback stage: redirect FSM encoding,
// registered payload layout and the mispredict rule.
package miriscv_wb_pkg;

    localparam int XLEN         = 32;
    localparam int GPR_ADDR_W   = 5;
    localparam int RETIRE_CNT_W = 64;

    typedef enum logic [0:0] {
        WB_RDR_IDLE = 1'b0,
        WB_RDR_DONE = 1'b1
    } wb_rdr_state_e;

    typedef struct packed {
        logic                  gpr_wr_en;
        logic [GPR_ADDR_W-1:0] gpr_wr_addr;
        logic [XLEN-1:0]       gpr_wr_data;
        logic                  branch;
        logic                  jal;
        logic                  jalr;
        logic [XLEN-1:0]       target_pc;
        logic [XLEN-1:0]       next_pc;
        logic                  prediction;
        logic                  br_j_taken;
    } wb_payload_t;

    localparam int WB_PAYLOAD_W = $bits(wb_payload_t);

    // jalr targets are never predicted, jal is always taken, branches compare outcome
    function automatic logic wb_mispredict(input logic branch, input logic jal,
                                           input logic jalr, input logic prediction,
                                           input logic taken);
        logic res;
        if (jalr) begin
            res = 1'b1;
        end else if (jal) begin
            res = ~prediction;
        end else if (branch) begin
            res = prediction ^ taken;
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/miriscv_writeback_stage_if.sv
// Memory-stage -> writeback bundle and writeback result bundle.
// The memory side (master) drives m_*, the writeback stage (slave) drives w_*.
interface miriscv_writeback_stage_if;
    import miriscv_wb_pkg::*;

    logic                    m_valid_i;
    logic                    m_gpr_wr_en_i;
    logic [GPR_ADDR_W-1:0]   m_gpr_wr_addr_i;
    logic [XLEN-1:0]         m_gpr_wr_data_i;
    logic                    m_branch_i;
    logic                    m_jal_i;
    logic                    m_jalr_i;
    logic [XLEN-1:0]         m_target_pc_i;
    logic [XLEN-1:0]         m_next_pc_i;
    logic                    m_prediction_i;
    logic                    m_br_j_taken_i;

    logic                    w_valid_o;
    logic                    w_gpr_wr_en_o;
    logic [GPR_ADDR_W-1:0]   w_gpr_wr_addr_o;
    logic [XLEN-1:0]         w_gpr_wr_data_o;
    logic                    w_redirect_o;
    logic [XLEN-1:0]         w_redirect_pc_o;
    logic                    w_retire_o;
    logic [RETIRE_CNT_W-1:0] w_retire_cnt_o;

    modport master (
        output m_valid_i, m_gpr_wr_en_i, m_gpr_wr_addr_i, m_gpr_wr_data_i,
               m_branch_i, m_jal_i, m_jalr_i, m_target_pc_i, m_next_pc_i,
               m_prediction_i, m_br_j_taken_i,
        input  w_valid_o, w_gpr_wr_en_o, w_gpr_wr_addr_o, w_gpr_wr_data_o,
               w_redirect_o, w_redirect_pc_o, w_retire_o, w_retire_cnt_o
    );

    modport slave (
        input  m_valid_i, m_gpr_wr_en_i, m_gpr_wr_addr_i, m_gpr_wr_data_i,
               m_branch_i, m_jal_i, m_jalr_i, m_target_pc_i, m_next_pc_i,
               m_prediction_i, m_br_j_taken_i,
        output w_valid_o, w_gpr_wr_en_o, w_gpr_wr_addr_o, w_gpr_wr_data_o,
               w_redirect_o, w_redirect_pc_o, w_retire_o, w_retire_cnt_o
    );

endinterface

// File: rtl/miriscv_retire_counter.sv
// Free-running retired-instruction counter; wraps modulo 2^WIDTH.
module miriscv_retire_counter
    import miriscv_wb_pkg::*;
#(
    parameter int unsigned WIDTH = RETIRE_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // next count
    always_comb begin
        if (en_i) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/miriscv_writeback_stage.sv
// Writeback stage: registers the memory-stage bundle, issues one GPR write and
// one redirect pulse per instruction. MIRISCV_WB_RETIRE_CNT_EN adds the retire counter.
module miriscv_writeback_stage
    import miriscv_wb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic cu_stall_w_i,
    input  logic cu_kill_w_i,
    miriscv_writeback_stage_if.slave wb_if
);

    logic                    valid_q;
    logic                    valid_d;
    wb_payload_t             payload_in_s;
    wb_payload_t             payload_q;
    wb_payload_t             payload_d;
    wb_rdr_state_e           state_q;
    wb_rdr_state_e           state_d;
    logic                    mispredict_s;
    logic                    redirect_s;
    logic [XLEN-1:0]         redirect_pc_s;
    logic                    retire_s;
    logic [RETIRE_CNT_W-1:0] retire_cnt_s;

    // gather the incoming bundle
    always_comb begin
        payload_in_s.gpr_wr_en   = wb_if.m_gpr_wr_en_i;
        payload_in_s.gpr_wr_addr = wb_if.m_gpr_wr_addr_i;
        payload_in_s.gpr_wr_data = wb_if.m_gpr_wr_data_i;
        payload_in_s.branch      = wb_if.m_branch_i;
        payload_in_s.jal         = wb_if.m_jal_i;
        payload_in_s.jalr        = wb_if.m_jalr_i;
        payload_in_s.target_pc   = wb_if.m_target_pc_i;
        payload_in_s.next_pc     = wb_if.m_next_pc_i;
        payload_in_s.prediction  = wb_if.m_prediction_i;
        payload_in_s.br_j_taken  = wb_if.m_br_j_taken_i;
    end

    // kill beats stall; a killed slot may keep its stale payload
    always_comb begin
        if (cu_stall_w_i) begin
            payload_d = payload_q;
        end else begin
            payload_d = payload_in_s;
        end
        if (cu_kill_w_i) begin
            valid_d = 1'b0;
        end else if (!cu_stall_w_i) begin
            valid_d = wb_if.m_valid_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // pipeline register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            payload_q <= wb_payload_t'({WB_PAYLOAD_W{1'b0}});
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    // mispredict and redirect target from the registered payload
    always_comb begin
        mispredict_s = wb_mispredict(payload_q.branch, payload_q.jal, payload_q.jalr,
                                     payload_q.prediction, payload_q.br_j_taken);
        if (payload_q.jal || payload_q.jalr || payload_q.br_j_taken) begin
            redirect_pc_s = payload_q.target_pc;
        end else begin
            redirect_pc_s = payload_q.next_pc;
        end
    end

    // redirect FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WB_RDR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE remembers a pulse already sent while the instruction sits stalled
    always_comb begin
        case (state_q)
            WB_RDR_IDLE: begin
                if (redirect_s && cu_stall_w_i) begin
                    state_d = WB_RDR_DONE;
                end else begin
                    state_d = WB_RDR_IDLE;
                end
            end
            WB_RDR_DONE: begin
                if (cu_kill_w_i || !cu_stall_w_i) begin
                    state_d = WB_RDR_IDLE;
                end else begin
                    state_d = WB_RDR_DONE;
                end
            end
            default: state_d = WB_RDR_IDLE;
        endcase
    end

    // redirect FSM output
    always_comb begin
        case (state_q)
            WB_RDR_IDLE: redirect_s = valid_q & mispredict_s & ~cu_kill_w_i;
            WB_RDR_DONE: redirect_s = 1'b0;
            default:     redirect_s = 1'b0;
        endcase
    end

    assign retire_s = valid_q & ~cu_stall_w_i & ~cu_kill_w_i;

`ifdef MIRISCV_WB_RETIRE_CNT_EN
    miriscv_retire_counter #(
        .WIDTH (RETIRE_CNT_W)
    ) u_retire_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (retire_s),
        .cnt_o (retire_cnt_s)
    );
`else
    assign retire_cnt_s = {RETIRE_CNT_W{1'b0}};
`endif

    assign wb_if.w_valid_o       = valid_q;
    assign wb_if.w_gpr_wr_en_o   = payload_q.gpr_wr_en & valid_q & ~cu_stall_w_i;
    assign wb_if.w_gpr_wr_addr_o = payload_q.gpr_wr_addr;
    assign wb_if.w_gpr_wr_data_o = payload_q.gpr_wr_data;
    assign wb_if.w_redirect_o    = redirect_s;
    assign wb_if.w_redirect_pc_o = redirect_pc_s;
    assign wb_if.w_retire_o      = retire_s;
    assign wb_if.w_retire_cnt_o  = retire_cnt_s;

endmodule

// File: tb/tb_miriscv_writeback_stage.sv
// Self-checking bench for miriscv_writeback_stage: instruction-level model plus
// hand-computed directed expectations. Honours MIRISCV_WB_RETIRE_CNT_EN.
module tb_miriscv_writeback_stage;

    logic clk;
    logic rst;
    logic stall;
    logic kill;
    int   n_chk;
    int   n_pass;

    miriscv_writeback_stage_if wb_if ();

    miriscv_writeback_stage dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cu_stall_w_i (stall),
        .cu_kill_w_i  (kill),
        .wb_if        (wb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction-level model: what instruction sits in WB and whether it already redirected
    logic        chk_en;
    logic        mv, mwr, mbr, mjal, mjalr, mpred, mtaken, mpulsed;
    logic [4:0]  maddr;
    logic [31:0] mdata, mtgt, mnpc;
    logic [63:0] mcnt;
    logic [63:0] cnt_ofs;
    logic        exp_misp, exp_redirect, exp_retire, exp_wr;
    logic [31:0] exp_pc;
    logic [63:0] exp_cnt;

    always_comb begin
        if (mjalr)      exp_misp = 1'b1;
        else if (mjal)  exp_misp = !mpred;
        else if (mbr)   exp_misp = (mpred != mtaken);
        else            exp_misp = 1'b0;
        exp_pc       = (mjal || mjalr || mtaken) ? mtgt : mnpc;
        exp_redirect = mv && exp_misp && !kill && !mpulsed;
        exp_retire   = mv && !stall && !kill;
        exp_wr       = mv && mwr && !stall;
`ifdef MIRISCV_WB_RETIRE_CNT_EN
        exp_cnt      = mcnt + cnt_ofs;
`else
        exp_cnt      = 64'd0;
`endif
    end

    always @(posedge clk) begin
        if (rst) begin
            chk_en <= 1'b1;
            mv <= 1'b0; mwr <= 1'b0; mbr <= 1'b0; mjal <= 1'b0; mjalr <= 1'b0;
            mpred <= 1'b0; mtaken <= 1'b0; mpulsed <= 1'b0;
            maddr <= 5'd0; mdata <= 32'd0; mtgt <= 32'd0; mnpc <= 32'd0;
            mcnt <= 64'd0;
        end else begin
            if (!stall) begin
                mwr <= wb_if.m_gpr_wr_en_i; maddr <= wb_if.m_gpr_wr_addr_i;
                mdata <= wb_if.m_gpr_wr_data_i; mbr <= wb_if.m_branch_i;
                mjal <= wb_if.m_jal_i; mjalr <= wb_if.m_jalr_i;
                mtgt <= wb_if.m_target_pc_i; mnpc <= wb_if.m_next_pc_i;
                mpred <= wb_if.m_prediction_i; mtaken <= wb_if.m_br_j_taken_i;
            end
            mv      <= kill ? 1'b0 : (!stall ? wb_if.m_valid_i : mv);
            mpulsed <= (kill || !stall) ? 1'b0 : (mpulsed || exp_redirect);
            mcnt    <= mcnt + {63'd0, exp_retire};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en === 1'b1) begin
            chk("valid", {63'd0, wb_if.w_valid_o}, {63'd0, mv});
            chk("gpr_wr_en", {63'd0, wb_if.w_gpr_wr_en_o}, {63'd0, exp_wr});
            if (mv) begin
                chk("gpr_wr_addr", {59'd0, wb_if.w_gpr_wr_addr_o}, {59'd0, maddr});
                chk("gpr_wr_data", {32'd0, wb_if.w_gpr_wr_data_o}, {32'd0, mdata});
            end
            chk("redirect", {63'd0, wb_if.w_redirect_o}, {63'd0, exp_redirect});
            if (exp_redirect) chk("redirect_pc", {32'd0, wb_if.w_redirect_pc_o}, {32'd0, exp_pc});
            chk("retire", {63'd0, wb_if.w_retire_o}, {63'd0, exp_retire});
            chk("retire_cnt", wb_if.w_retire_cnt_o, exp_cnt);
        end
    end

    task automatic set_m(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d,
                         input logic br, input logic jl, input logic jr,
                         input logic [31:0] tgt, input logic [31:0] npc,
                         input logic pr, input logic tk);
        wb_if.m_valid_i = v; wb_if.m_gpr_wr_en_i = we; wb_if.m_gpr_wr_addr_i = a;
        wb_if.m_gpr_wr_data_i = d; wb_if.m_branch_i = br; wb_if.m_jal_i = jl;
        wb_if.m_jalr_i = jr; wb_if.m_target_pc_i = tgt; wb_if.m_next_pc_i = npc;
        wb_if.m_prediction_i = pr; wb_if.m_br_j_taken_i = tk;
    endtask

    task automatic clr_m();
        set_m(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; chk_en = 1'b0; cnt_ofs = 64'd0;
        rst = 1'b1; stall = 1'b0; kill = 1'b0;
        clr_m();
        step(); step();
        rst = 1'b0;
        peek();
        chk("lit_rst_valid", {63'd0, wb_if.w_valid_o}, 64'd0);
        chk("lit_rst_redirect", {63'd0, wb_if.w_redirect_o}, 64'd0);
        chk("lit_rst_cnt", wb_if.w_retire_cnt_o, 64'd0);

        // single ALU op
        set_m(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(); clr_m(); peek();
        chk("lit_alu_wr_en", {63'd0, wb_if.w_gpr_wr_en_o}, 64'd1);
        chk("lit_alu_addr", {59'd0, wb_if.w_gpr_wr_addr_o}, 64'd5);
        chk("lit_alu_data", {32'd0, wb_if.w_gpr_wr_data_o}, 64'h1234);
        chk("lit_alu_retire", {63'd0, wb_if.w_retire_o}, 64'd1);
        step(); peek();
`ifdef MIRISCV_WB_RETIRE_CNT_EN
        chk("lit_alu_cnt", wb_if.w_retire_cnt_o, 64'd1);
`else
        chk("lit_alu_cnt_off", wb_if.w_retire_cnt_o, 64'd0);
`endif

        // branch predicted not-taken, taken -> target; then predicted taken, not taken -> next_pc
        set_m(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h84, 1'b0, 1'b1);
        step(); clr_m(); peek();
        chk("lit_br_nt_redirect", {63'd0, wb_if.w_redirect_o}, 64'd1);
        chk("lit_br_nt_pc", {32'd0, wb_if.w_redirect_pc_o}, 64'h80);
        step(); peek();
        chk("lit_br_pulse_end", {63'd0, wb_if.w_redirect_o}, 64'd0);
        set_m(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h44, 1'b1, 1'b0);
        step(); clr_m(); peek();
        chk("lit_br_t_redirect", {63'd0, wb_if.w_redirect_o}, 64'd1);
        chk("lit_br_t_pc", {32'd0, wb_if.w_redirect_pc_o}, 64'h44);

        // mispredicting jalr held for three stall cycles
        set_m(1'b1, 1'b1, 5'd1, 32'h48, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0, 1'b1, 1'b1);
        step(); clr_m(); stall = 1'b1; peek();
        chk("lit_jalr_redirect", {63'd0, wb_if.w_redirect_o}, 64'd1);
        chk("lit_jalr_pc", {32'd0, wb_if.w_redirect_pc_o}, 64'h200);
        chk("lit_jalr_nowr0", {63'd0, wb_if.w_gpr_wr_en_o}, 64'd0);
        step(); peek();
        chk("lit_jalr_once1", {63'd0, wb_if.w_redirect_o}, 64'd0);
        step(); peek();
        chk("lit_jalr_once2", {63'd0, wb_if.w_redirect_o}, 64'd0);
        chk("lit_jalr_nowr2", {63'd0, wb_if.w_gpr_wr_en_o}, 64'd0);
        step(); stall = 1'b0; peek();
        chk("lit_jalr_release_wr", {63'd0, wb_if.w_gpr_wr_en_o}, 64'd1);
        chk("lit_jalr_release_rdr", {63'd0, wb_if.w_redirect_o}, 64'd0);
        step(); peek();
        chk("lit_jalr_single_wr", {63'd0, wb_if.w_gpr_wr_en_o}, 64'd0);

        // kill together with stall on a valid mispredicting write
        set_m(1'b1, 1'b1, 5'd7, 32'hAA, 1'b1, 1'b0, 1'b0, 32'h300, 32'h304, 1'b0, 1'b1);
        step(); clr_m(); stall = 1'b1; kill = 1'b1; peek();
        chk("lit_kill_wr", {63'd0, wb_if.w_gpr_wr_en_o}, 64'd0);
        chk("lit_kill_rdr", {63'd0, wb_if.w_redirect_o}, 64'd0);
        chk("lit_kill_retire", {63'd0, wb_if.w_retire_o}, 64'd0);
        step(); stall = 1'b0; kill = 1'b0; peek();
        chk("lit_kill_valid", {63'd0, wb_if.w_valid_o}, 64'd0);
        chk("lit_kill_after_rdr", {63'd0, wb_if.w_redirect_o}, 64'd0);

        // back-to-back mispredicts
        set_m(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 32'h400, 32'h404, 1'b0, 1'b1);
        step();
        set_m(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h500, 32'h408, 1'b0, 1'b1);
        peek();
        chk("lit_b2b_pc0", {32'd0, wb_if.w_redirect_pc_o}, 64'h400);
        step(); clr_m(); peek();
        chk("lit_b2b_rdr1", {63'd0, wb_if.w_redirect_o}, 64'd1);
        chk("lit_b2b_pc1", {32'd0, wb_if.w_redirect_pc_o}, 64'h500);

        // reset while stalled in the already-redirected state
        set_m(1'b1, 1'b1, 5'd3, 32'h99, 1'b0, 1'b0, 1'b1, 32'h600, 32'h0, 1'b0, 1'b0);
        step(); clr_m(); stall = 1'b1; peek();
        step(); rst = 1'b1; peek();
        step(); rst = 1'b0; peek();
        chk("lit_rst2_valid", {63'd0, wb_if.w_valid_o}, 64'd0);
        chk("lit_rst2_wr", {63'd0, wb_if.w_gpr_wr_en_o}, 64'd0);
        chk("lit_rst2_rdr", {63'd0, wb_if.w_redirect_o}, 64'd0);
        chk("lit_rst2_data", {32'd0, wb_if.w_gpr_wr_data_o}, 64'd0);
        chk("lit_rst2_pc", {32'd0, wb_if.w_redirect_pc_o}, 64'd0);
        chk("lit_rst2_cnt", wb_if.w_retire_cnt_o, 64'd0);
        stall = 1'b0;
        set_m(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h700, 32'h0, 1'b1, 1'b1);
        step(); clr_m(); peek();
        chk("lit_rst2_idle_rdr", {63'd0, wb_if.w_redirect_o}, 64'd1);

`ifdef MIRISCV_WB_RETIRE_CNT_EN
        // counter wrap from all-ones
        set_m(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(); clr_m();
        force dut.u_retire_counter.cnt_q = {64{1'b1}};
        #1;
        release dut.u_retire_counter.cnt_q;
        cnt_ofs = {64{1'b1}} - mcnt;
        peek();
        chk("lit_wrap_pre", wb_if.w_retire_cnt_o, {64{1'b1}});
        step(); peek();
        chk("lit_wrap_post", wb_if.w_retire_cnt_o, 64'd0);
`endif

        // mixed traffic checked by the model
        for (int i = 0; i < 80; i++) begin
            logic [2:0] kind;
            kind = 3'($urandom_range(0, 3));
            set_m(1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                  kind == 3'd1, kind == 3'd2, kind == 3'd3,
                  $urandom, $urandom, 1'($urandom), 1'($urandom));
            stall = ($urandom_range(0, 2) == 0);
            kill  = ($urandom_range(0, 6) == 0);
            step();
        end
        clr_m(); stall = 1'b0; kill = 1'b0;
        step(); step(); peek();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
